// File: rtl/ival_pack.sv
// rtl/ival_pack.sv - assembles the 32-bit ival word from foo/baz/egg field writes (optional IVAL_PACK_COUNT_EN)
module ival_pack #(
  parameter int               FOO_W   = 14,
  parameter logic             FILL    = 1'b0,
  parameter logic [FOO_W-1:0] FOO_RST = {FOO_W{1'b1}}
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             fld_valid,
  output logic             fld_ready,
  input  logic [1:0]       fld_sel,
  input  logic [FOO_W-1:0] fld_data,
  output logic             fld_err,
`ifdef IVAL_PACK_COUNT_EN
  output logic [7:0]       word_cnt,
  output logic             fld_dup,
`endif
  output logic             ival_valid,
  input  logic             ival_ready,
  output logic [31:0]      ival
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [2:0]       mask_q;
  logic [FOO_W-1:0] foo_q;
  logic [2:0]       baz_q;
  logic [2:0]       egg_q;
  logic [2:0]       sel_bit;
  logic             accept;
  logic             legal;
  logic             done;

  // accept depends on state only, so there is no path from ival_ready to fld_ready
  assign accept = fld_valid && (state_q == COLLECT);
  assign legal  = (fld_sel != 2'd3);
  assign done   = (state_q == HOLD) && ival_ready;

  // one-hot mask bit addressed by the current field select; illegal select maps to none
  always_comb begin
    sel_bit = 3'b000;
    case (fld_sel)
      2'd0:    sel_bit = 3'b001;
      2'd1:    sel_bit = 3'b010;
      2'd2:    sel_bit = 3'b100;
      default: sel_bit = 3'b000;
    endcase
  end

  // state register
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    fld_ready  = 1'b0;
    ival_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        fld_ready = 1'b1;
        if (accept && legal && ((mask_q | sel_bit) == 3'b111)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        ival_valid = 1'b1;
        if (ival_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // field registers, collection mask and error pulse; fields survive a transfer, the mask does not
  always_ff @(posedge sysclk) begin
    if (reset) begin
      mask_q  <= 3'b000;
      foo_q   <= FOO_RST;
      baz_q   <= 3'd0;
      egg_q   <= 3'd0;
      fld_err <= 1'b0;
    end else begin
      fld_err <= accept && !legal;
      if (accept) begin
        mask_q <= mask_q | sel_bit;
        case (fld_sel)
          2'd0:    foo_q <= fld_data;
          2'd1:    baz_q <= fld_data[2:0];
          2'd2:    egg_q <= fld_data[2:0];
          default: ;
        endcase
      end else if (done) begin
        mask_q <= 3'b000;
      end
    end
  end

`ifdef IVAL_PACK_COUNT_EN
  // transferred-word counter (wraps) and duplicate-field pulse
  always_ff @(posedge sysclk) begin
    if (reset) begin
      word_cnt <= 8'd0;
      fld_dup  <= 1'b0;
    end else begin
      fld_dup <= accept && ((mask_q & sel_bit) != 3'b000);
      if (done) begin
        word_cnt <= word_cnt + 8'd1;
      end
    end
  end
`endif

  // word composition: fill first, then overlay the fields at their fixed positions
  always_comb begin
    ival            = {32{FILL}};
    ival[31 -: FOO_W] = foo_q;
    ival[6:4]       = egg_q;
    ival[2:0]       = baz_q;
  end

endmodule

// File: tb/tb_ival_pack.sv
// tb/tb_ival_pack.sv - scoreboard bench for ival_pack
module tb_ival_pack;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        fld_valid;
  logic        fld_ready;
  logic [1:0]  fld_sel;
  logic [13:0] fld_data;
  logic        fld_err;
  logic        ival_valid;
  logic        ival_ready;
  logic [31:0] ival;
`ifdef IVAL_PACK_COUNT_EN
  logic [7:0]  word_cnt;
  logic        fld_dup;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 sysclk = ~sysclk;

  ival_pack dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .fld_valid  (fld_valid),
    .fld_ready  (fld_ready),
    .fld_sel    (fld_sel),
    .fld_data   (fld_data),
    .fld_err    (fld_err),
`ifdef IVAL_PACK_COUNT_EN
    .word_cnt   (word_cnt),
    .fld_dup    (fld_dup),
`endif
    .ival_valid (ival_valid),
    .ival_ready (ival_ready),
    .ival       (ival)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // drive one field write and return just after the edge that accepted it
  task automatic wr(input logic [1:0] s, input logic [13:0] d);
    int n = 0;
    fld_valid = 1'b1;
    fld_sel   = s;
    fld_data  = d;
    while (!fld_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL wr_timeout: got fld_ready=0 expected 1 within 50 cycles");
    end
    step();
    fld_valid = 1'b0;
  endtask

  // monitor: every transferred word is popped from the scoreboard and compared
  always @(negedge sysclk) begin
    if (!reset && ival_valid && ival_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL mon_unexpected: got word %h expected none", ival);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ival !== e) begin
          failures++;
          $display("FAIL mon_word: got %h expected %h", ival, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; fld_valid = 1'b0; fld_sel = 2'd0; fld_data = 14'd0; ival_ready = 1'b1;
    repeat (3) step();
    check("rst_ival", ival, 32'hFFFC0000);
    check("rst_valid", {31'd0, ival_valid}, 32'd0);
    check("rst_ready", {31'd0, fld_ready}, 32'd1);
    reset = 1'b0;
    step();
    check("idle_ival", ival, 32'hFFFC0000);
    check("idle_err", {31'd0, fld_err}, 32'd0);

    // basic word
    exp_q.push_back(32'h48D00025);
    wr(2'd0, 14'h1234);
    wr(2'd1, 14'h0005);
    check("w1_valid_early", {31'd0, ival_valid}, 32'd0);
    wr(2'd2, 14'h0002);
    check("w1_valid", {31'd0, ival_valid}, 32'd1);
    check("w1_ival", ival, 32'h48D00025);
    check("w1_ready_hold", {31'd0, fld_ready}, 32'd0);
    step();
    check("w1_ready_back", {31'd0, fld_ready}, 32'd1);
    check("w1_valid_off", {31'd0, ival_valid}, 32'd0);

    // rewrite of egg, word only after foo
    exp_q.push_back(32'h00000013);
    wr(2'd2, 14'h0007);
    wr(2'd2, 14'h0001);
`ifdef IVAL_PACK_COUNT_EN
    check("dup_pulse", {31'd0, fld_dup}, 32'd1);
`endif
    wr(2'd1, 14'h0003);
    check("w2_valid_early", {31'd0, ival_valid}, 32'd0);
    wr(2'd0, 14'h0000);
    check("w2_valid", {31'd0, ival_valid}, 32'd1);
    check("w2_ival", ival, 32'h00000013);
    step();

    // backpressure with fld_valid held
    ival_ready = 1'b0;
    exp_q.push_back(32'hAAA80061);
    wr(2'd0, 14'h2AAA);
    wr(2'd1, 14'h0001);
    wr(2'd2, 14'h0006);
    fld_valid = 1'b1; fld_sel = 2'd0; fld_data = 14'h1111;
    for (int i = 0; i < 5; i++) begin
      check("hold_ival", ival, 32'hAAA80061);
      check("hold_ready", {31'd0, fld_ready}, 32'd0);
      check("hold_valid", {31'd0, ival_valid}, 32'd1);
      step();
    end
    fld_valid = 1'b0;
    ival_ready = 1'b1;
    step();
    check("hold_done_valid", {31'd0, ival_valid}, 32'd0);
    check("hold_done_ival", ival, 32'hAAA80061);
`ifdef IVAL_PACK_COUNT_EN
    check("cnt_three", {24'd0, word_cnt}, 32'd3);
`endif

    // illegal select
    wr(2'd3, 14'h3FFF);
    check("err_pulse", {31'd0, fld_err}, 32'd1);
    check("err_ival", ival, 32'hAAA80061);
    check("err_ready", {31'd0, fld_ready}, 32'd1);
    step();
    check("err_clear", {31'd0, fld_err}, 32'd0);

    // reset coincident with third field
    wr(2'd0, 14'h0001);
    wr(2'd1, 14'h0007);
    fld_valid = 1'b1; fld_sel = 2'd2; fld_data = 14'h0003; reset = 1'b1;
    step();
    reset = 1'b0; fld_valid = 1'b0;
    check("rstmid_ival", ival, 32'hFFFC0000);
    check("rstmid_valid", {31'd0, ival_valid}, 32'd0);
    check("rstmid_ready", {31'd0, fld_ready}, 32'd1);
    step();
    check("rstmid_valid2", {31'd0, ival_valid}, 32'd0);
    exp_q.push_back(32'h00080042);
    wr(2'd2, 14'h0004);
    check("rstmid_mask", {31'd0, ival_valid}, 32'd0);
    wr(2'd0, 14'h0002);
    wr(2'd1, 14'h0002);
    check("w4_ival", ival, 32'h00080042);
    step();

    // reset drops a held word
    ival_ready = 1'b0;
    wr(2'd0, 14'h0005);
    wr(2'd1, 14'h0001);
    wr(2'd2, 14'h0001);
    check("drop_pre", {31'd0, ival_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ival_ready = 1'b1;
    check("drop_valid", {31'd0, ival_valid}, 32'd0);
    step();
    check("drop_valid2", {31'd0, ival_valid}, 32'd0);

`ifdef IVAL_PACK_COUNT_EN
    check("cnt_rst", {24'd0, word_cnt}, 32'd0);
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(32'h00040011);
      wr(2'd0, 14'h0001);
      wr(2'd1, 14'h0001);
      wr(2'd2, 14'h0001);
      step();
    end
    check("cnt_wrap", {24'd0, word_cnt}, 32'd0);
`endif

    repeat (3) step();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
